// File: rtl/bus_slave_mem_param.sv
// ---------------------------------------------------------------------------
// bus_slave_mem_param
//
// Parametrised memory-mapped bus slave. A transfer is requested by raising
// SEL with the TRANS bit of HADDR set. The slave captures the address, the
// write flag and the write data, optionally spends WAIT_CYCLES wait states,
// performs one memory access and then pulses HREADY for a single cycle
// together with a response code.
//
// Parameters:
//   DATA_W      data bus / memory word width
//   ADDR_W      word-address bits (1..12), depth = 2**ADDR_W
//   WAIT_CYCLES wait states before the access (0..15)
//   RO_BASE     first read-only word address (2**ADDR_W = no read-only area)
//
// Ports:
//   CLK     in   bus clock, rising edge
//   RST_N   in   asynchronous active-low reset
//   SEL     in   slave select from the bus decoder
//   HADDR   in   [15] TRANS, [12] HWRITE, [11:0] word address
//   HWDATA  in   write data, sampled together with the address
//   MLOCK   in   locked transfer, cannot be aborted during wait states
//   HRDATA  out  registered read data, held until the next good read
//   HRESP   out  00 OKAY, 01 ERROR, 10 RETRY
//   HREADY  out  registered one-cycle completion strobe
// ---------------------------------------------------------------------------
module bus_slave_mem_param #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 12,
   parameter int WAIT_CYCLES = 0,
   parameter int RO_BASE     = 2**ADDR_W
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              SEL,
   input  logic [15:0]       HADDR,
   input  logic [DATA_W-1:0] HWDATA,
   input  logic              MLOCK,
   output logic [DATA_W-1:0] HRDATA,
   output logic [1:0]        HRESP,
   output logic              HREADY
);

   localparam int DEPTH = 2**ADDR_W;

   localparam logic [1:0] RESP_OKAY  = 2'b00;
   localparam logic [1:0] RESP_ERROR = 2'b01;
   localparam logic [1:0] RESP_RETRY = 2'b10;

   // The counter is preloaded with WAIT_CYCLES-1 so that the FSM spends
   // exactly WAIT_CYCLES cycles in the wait state before the access.
   localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ACCESS,
      ST_RESP
   } state_t;

   state_t              state_q;
   logic [3:0]          cnt_q;
   logic [11:0]         addr_q;
   logic                write_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W-1:0]   hrdata_q;
   logic [1:0]          hresp_q;
   logic                hready_q;

   logic [DATA_W-1:0]   mem [0:DEPTH-1];

   logic [ADDR_W-1:0]   wordIdx;
   logic                outOfRange;
   logic                roHit;
   logic                memWe;
   logic                unusedHaddr;

   // Decode of the captured transfer. Address bits above ADDR_W must be zero,
   // otherwise the transfer points outside this slave's memory. Writes into
   // the upper read-only region are refused. The memory write enable is only
   // ever raised in the access state of a transfer that passed both checks.
   always_comb begin
      wordIdx     = addr_q[ADDR_W-1:0];
      outOfRange  = ((addr_q >> ADDR_W) != 12'd0);
      roHit       = write_q && (32'(wordIdx) >= 32'(RO_BASE));
      memWe       = (state_q == ST_ACCESS) && write_q && !outOfRange && !roHit;
      unusedHaddr = ^HADDR[14:13];
   end

   // Memory array. Deliberately not reset: the contents survive RST_N, and a
   // reset during a transfer returns the FSM to idle before it can reach the
   // access state, so a pending write is dropped.
   always_ff @(posedge CLK) begin
      if (memWe) begin
         mem[wordIdx] <= wdata_q;
      end
   end

   // Transfer FSM with registered outputs. Idle and response states share the
   // same request decode so that a new transfer can be accepted straight out
   // of the response cycle (back-to-back). The wait state can be abandoned by
   // the master dropping SEL unless the transfer is locked; the access state
   // lasts one edge and always ends in the one-cycle response state.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 4'd0;
         addr_q   <= 12'd0;
         write_q  <= 1'b0;
         wdata_q  <= '0;
         hrdata_q <= '0;
         hresp_q  <= RESP_OKAY;
         hready_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_RESP: begin
               hready_q <= 1'b0;
               if (SEL && HADDR[15]) begin
                  addr_q  <= HADDR[11:0];
                  write_q <= HADDR[12];
                  wdata_q <= HWDATA;
                  cnt_q   <= WAIT_LOAD;
                  hresp_q <= RESP_OKAY;
                  state_q <= (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
               end else if (SEL) begin
                  hresp_q  <= RESP_ERROR;
                  hready_q <= 1'b1;
                  state_q  <= ST_RESP;
               end else begin
                  hresp_q <= RESP_OKAY;
                  state_q <= ST_IDLE;
               end
            end
            ST_WAIT: begin
               if (!SEL && !MLOCK) begin
                  hresp_q  <= RESP_RETRY;
                  hready_q <= 1'b1;
                  state_q  <= ST_RESP;
               end else if (cnt_q == 4'd0) begin
                  state_q <= ST_ACCESS;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            ST_ACCESS: begin
               hready_q <= 1'b1;
               state_q  <= ST_RESP;
               if (outOfRange || roHit) begin
                  hresp_q <= RESP_ERROR;
               end else begin
                  hresp_q <= RESP_OKAY;
                  if (!write_q) begin
                     hrdata_q <= mem[wordIdx];
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign HRDATA = hrdata_q;
   assign HRESP  = hresp_q;
   assign HREADY = hready_q;

endmodule

// File: tb/tb_bus_slave_mem_param.sv
// ---------------------------------------------------------------------------
// tb_bus_slave_mem_param
//
// Self-checking bench for bus_slave_mem_param. Three instances with different
// parameter sets are driven independently:
//   dut 0 : ADDR_W=12, WAIT_CYCLES=0, no read-only region
//   dut 1 : ADDR_W=10, WAIT_CYCLES=3, RO_BASE=0x300
//   dut 2 : ADDR_W=12, WAIT_CYCLES=4, no read-only region
// A behavioural model per instance (word array plus last read value) predicts
// response code, completion latency and read data for every transfer.
// ---------------------------------------------------------------------------
module tb_bus_slave_mem_param;

   logic        CLK;
   logic        RST_N;
   logic        sel    [3];
   logic [15:0] haddr  [3];
   logic [31:0] hwdata [3];
   logic        mlock  [3];
   logic [31:0] hrdata [3];
   logic [1:0]  hresp  [3];
   logic        hready [3];

   int checks = 0;
   int passes = 0;

   logic [31:0] modelMem    [3][4096];
   bit          known       [3][4096];
   logic [31:0] modelRdata  [3];

   bus_slave_mem_param #(.DATA_W(32), .ADDR_W(12), .WAIT_CYCLES(0)) dut0 (
      .CLK(CLK), .RST_N(RST_N), .SEL(sel[0]), .HADDR(haddr[0]), .HWDATA(hwdata[0]),
      .MLOCK(mlock[0]), .HRDATA(hrdata[0]), .HRESP(hresp[0]), .HREADY(hready[0]));

   bus_slave_mem_param #(.DATA_W(32), .ADDR_W(10), .WAIT_CYCLES(3), .RO_BASE('h300)) dut1 (
      .CLK(CLK), .RST_N(RST_N), .SEL(sel[1]), .HADDR(haddr[1]), .HWDATA(hwdata[1]),
      .MLOCK(mlock[1]), .HRDATA(hrdata[1]), .HRESP(hresp[1]), .HREADY(hready[1]));

   bus_slave_mem_param #(.DATA_W(32), .ADDR_W(12), .WAIT_CYCLES(4)) dut2 (
      .CLK(CLK), .RST_N(RST_N), .SEL(sel[2]), .HADDR(haddr[2]), .HWDATA(hwdata[2]),
      .MLOCK(mlock[2]), .HRDATA(hrdata[2]), .HRESP(hresp[2]), .HREADY(hready[2]));

   // Free-running bus clock, 10 time units per period.
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Parameter lookup for each instance, used by the reference model.
   function automatic int waitOf(input int k);
      return (k == 0) ? 0 : (k == 1) ? 3 : 4;
   endfunction

   function automatic int awOf(input int k);
      return (k == 1) ? 10 : 12;
   endfunction

   function automatic int roOf(input int k);
      return (k == 1) ? 'h300 : (1 << awOf(k));
   endfunction

   // Idle a number of cycles with all selects low.
   task automatic idle(input int n);
      repeat (n) @(negedge CLK);
   endtask

   // One complete transfer on instance k, started at the current negedge.
   // The model predicts the outcome before the request is driven; the bench
   // then counts negedges until HREADY and compares latency, response and
   // read data. Words whose contents were never written cannot be predicted,
   // so the first read of such a word only fixes the model's copy.
   task automatic xfer(input int k, input bit wr, input logic [11:0] a,
                       input logic [31:0] d, input bit trans);
      int n;
      bit done;
      int expN;
      logic [1:0] expResp;
      logic [1:0] respAtFirst;
      bit learn;
      logic [11:0] mask;
      logic [11:0] idx;
      mask  = 12'((32'd1 << awOf(k)) - 1);
      idx   = a & mask;
      learn = 1'b0;
      respAtFirst = 2'b11;
      if (!trans) begin
         expN    = 1;
         expResp = 2'b01;
      end else begin
         expN = waitOf(k) + 2;
         if ((a & ~mask) != 12'd0) begin
            expResp = 2'b01;
         end else if (wr && int'(idx) >= roOf(k)) begin
            expResp = 2'b01;
         end else begin
            expResp = 2'b00;
            if (wr) begin
               modelMem[k][idx] = d;
               known[k][idx]    = 1'b1;
            end else if (known[k][idx]) begin
               modelRdata[k] = modelMem[k][idx];
            end else begin
               learn = 1'b1;
            end
         end
      end
      sel[k]    = 1'b1;
      haddr[k]  = {trans, 2'b00, wr, a};
      hwdata[k] = d;
      mlock[k]  = 1'b1;
      done = 1'b0;
      n    = 0;
      while (!done && n < 40) begin
         n++;
         @(negedge CLK);
         if (n == 1) begin
            respAtFirst = hresp[k];
            sel[k]   = 1'b0;
            haddr[k] = 16'h0000;
         end
         if (hready[k]) done = 1'b1;
      end
      checks++;
      if (!done || n != expN)
         $display("[TB] FAIL latency dut%0d addr=%h wr=%0d: got %0d (done=%0d) required %0d",
                  k, a, wr, n, done, expN);
      else passes++;
      checks++;
      if (hresp[k] !== expResp)
         $display("[TB] FAIL hresp dut%0d addr=%h wr=%0d: got %b required %b", k, a, wr, hresp[k], expResp);
      else passes++;
      if (trans && waitOf(k) > 0) begin
         checks++;
         if (respAtFirst !== 2'b00)
            $display("[TB] FAIL wait_hresp dut%0d addr=%h: got %b required 00", k, a, respAtFirst);
         else passes++;
      end
      if (learn) begin
         modelMem[k][idx] = hrdata[k];
         known[k][idx]    = 1'b1;
         modelRdata[k]    = hrdata[k];
      end else begin
         checks++;
         if (hrdata[k] !== modelRdata[k])
            $display("[TB] FAIL hrdata dut%0d addr=%h wr=%0d: got %h required %h",
                     k, a, wr, hrdata[k], modelRdata[k]);
         else passes++;
      end
   endtask

   // Power-on reset: all outputs of every instance must be zero.
   task automatic test_reset();
      RST_N = 1'b1;
      for (int k = 0; k < 3; k++) begin
         sel[k] = 1'b0; haddr[k] = 16'h0; hwdata[k] = 32'h0; mlock[k] = 1'b0;
         modelRdata[k] = 32'h0;
      end
      #2 RST_N = 1'b0;
      #2;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if ({hrdata[k], hresp[k], hready[k]} !== 35'd0)
            $display("[TB] FAIL reset dut%0d: got hrdata=%h hresp=%b hready=%b required all zero",
                     k, hrdata[k], hresp[k], hready[k]);
         else passes++;
      end
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      idle(1);
   endtask

   // Zero-wait write then read of the same word.
   task automatic test_basic();
      xfer(0, 1'b1, 12'h005, 32'hDEADBEEF, 1'b1);
      idle(1);
      xfer(0, 1'b0, 12'h005, 32'h0, 1'b1);
      idle(2);
   endtask

   // Wait-state latency on the three-wait instance.
   task automatic test_wait_states();
      xfer(1, 1'b1, 12'h010, 32'hA5A5_0010, 1'b1);
      idle(1);
      xfer(1, 1'b0, 12'h010, 32'h0, 1'b1);
      idle(1);
   endtask

   // Out-of-range and read-only protection on the 10-bit instance.
   task automatic test_protect();
      xfer(1, 1'b1, 12'h005, 32'h0BAD_F00D, 1'b1);
      xfer(1, 1'b1, 12'h7FF, 32'h12345678, 1'b1);
      xfer(1, 1'b1, 12'h405, 32'h12345678, 1'b1);
      xfer(1, 1'b0, 12'h300, 32'h0, 1'b1);
      xfer(1, 1'b1, 12'h300, 32'h12345678, 1'b1);
      xfer(1, 1'b0, 12'h300, 32'h0, 1'b1);
      xfer(1, 1'b0, 12'h005, 32'h0, 1'b1);
      xfer(1, 1'b0, 12'h7FF, 32'h0, 1'b1);
      xfer(1, 1'b1, 12'h2FF, 32'h2FF0_2FF0, 1'b1);
      xfer(1, 1'b0, 12'h2FF, 32'h0, 1'b1);
      idle(1);
   endtask

   // Dropping SEL in the second wait cycle: aborts when unlocked, ignored
   // when locked. The target word is read back afterwards.
   task automatic test_abort();
      int n;
      bit done;
      int expN;
      logic [1:0] expResp;
      xfer(2, 1'b1, 12'h020, 32'h1111_1111, 1'b1);
      idle(1);
      for (int pass = 0; pass < 2; pass++) begin
         sel[2]    = 1'b1;
         haddr[2]  = {1'b1, 2'b00, 1'b1, 12'h020};
         hwdata[2] = (pass == 0) ? 32'hBAD0_BAD0 : 32'h2222_2222;
         mlock[2]  = (pass == 1);
         expN      = (pass == 0) ? 3 : waitOf(2) + 2;
         expResp   = (pass == 0) ? 2'b10 : 2'b00;
         if (pass == 1) begin
            modelMem[2][12'h020] = 32'h2222_2222;
         end
         done = 1'b0;
         n    = 0;
         while (!done && n < 40) begin
            n++;
            @(negedge CLK);
            if (n == 1) haddr[2] = 16'h0000;
            if (n == 2) sel[2] = 1'b0;
            if (hready[2]) done = 1'b1;
         end
         checks++;
         if (!done || n != expN)
            $display("[TB] FAIL abort_latency lock=%0d: got %0d required %0d", pass, n, expN);
         else passes++;
         checks++;
         if (hresp[2] !== expResp)
            $display("[TB] FAIL abort_hresp lock=%0d: got %b required %b", pass, hresp[2], expResp);
         else passes++;
         mlock[2] = 1'b0;
         idle(1);
         xfer(2, 1'b0, 12'h020, 32'h0, 1'b1);
         idle(1);
      end
   endtask

   // TRANS=0 error, then back-to-back transfers issued from response cycles.
   task automatic test_back_to_back();
      xfer(0, 1'b0, 12'h005, 32'h0, 1'b0);
      xfer(0, 1'b1, 12'h001, 32'h0000_0001, 1'b1);
      xfer(0, 1'b1, 12'h002, 32'hC0DE_0002, 1'b1);
      xfer(0, 1'b0, 12'h001, 32'h0, 1'b1);
      xfer(0, 1'b0, 12'h002, 32'h0, 1'b1);
      xfer(1, 1'b1, 12'h033, 32'h3333_0033, 1'b1);
      xfer(1, 1'b0, 12'h033, 32'h0, 1'b1);
      xfer(0, 1'b0, 12'h005, 32'h0, 1'b0);
      @(negedge CLK);
      checks++;
      if (hready[0] !== 1'b0 || hresp[0] !== 2'b00)
         $display("[TB] FAIL idle_after_resp: got hready=%b hresp=%b required 0 00", hready[0], hresp[0]);
      else passes++;
      idle(1);
   endtask

   // Randomised traffic on every instance against the model.
   task automatic test_random();
      bit wr;
      bit trans;
      logic [11:0] a;
      logic [11:0] idx;
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 30; i++) begin
            if (k == 1) a = 12'($urandom_range(0, 'h7FF));
            else        a = 12'($urandom_range(0, 31));
            if (k == 1 && $urandom_range(0, 2) == 0) a = 12'($urandom_range('h2F8, 'h307));
            wr    = 1'($urandom_range(0, 1));
            trans = ($urandom_range(0, 7) != 0);
            idx   = a & 12'((32'd1 << awOf(k)) - 1);
            if (!wr && a == idx && !known[k][idx]) wr = 1'b1;
            xfer(k, wr, a, $urandom, trans);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
         end
         idle(1);
      end
   endtask

   // Asynchronous reset while dut2 waits on a write and dut0 holds an error
   // response; the write must be lost and every output cleared at once.
   task automatic test_reset_midwrite();
      xfer(0, 1'b0, 12'h002, 32'h0, 1'b1);
      idle(1);
      sel[0]    = 1'b1;
      haddr[0]  = 16'h0005;
      sel[2]    = 1'b1;
      haddr[2]  = {1'b1, 2'b00, 1'b1, 12'h020};
      hwdata[2] = 32'hFEED_F00D;
      mlock[2]  = 1'b1;
      @(negedge CLK);
      sel[0] = 1'b0;
      checks++;
      if (hready[0] !== 1'b1 || hresp[0] !== 2'b01)
         $display("[TB] FAIL pre_reset_resp: got hready=%b hresp=%b required 1 01", hready[0], hresp[0]);
      else passes++;
      #2 RST_N = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         modelRdata[k] = 32'h0;
         checks++;
         if ({hrdata[k], hresp[k], hready[k]} !== 35'd0)
            $display("[TB] FAIL async_reset dut%0d: got hrdata=%h hresp=%b hready=%b required all zero",
                     k, hrdata[k], hresp[k], hready[k]);
         else passes++;
      end
      sel[2]   = 1'b0;
      haddr[2] = 16'h0;
      mlock[2] = 1'b0;
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      idle(1);
      xfer(2, 1'b0, 12'h020, 32'h0, 1'b1);
      idle(1);
      xfer(0, 1'b0, 12'h002, 32'h0, 1'b1);
      idle(1);
   endtask

   // Scenario sequence and the final summary.
   initial begin
      test_reset();
      test_basic();
      test_wait_states();
      test_protect();
      test_abort();
      test_back_to_back();
      test_random();
      test_reset_midwrite();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
